// File: rtl/sreg_arb_pkg.sv
// Shared definitions for the shared-register round-robin arbiter family:
// op codes, FSM state encodings and a small width helper.
package sreg_arb_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SET  = 2'b01,
    OP_CLR  = 2'b10,
    OP_TOG  = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_rr_arbiter_if.sv
// Requester-facing bus of the shared register arbiter: flattened per-requester
// request/op/data words going in, ack/grant/register contents coming back.
interface shared_reg_rr_arbiter_if #(
  parameter int W    = 8,
  parameter int NREQ = 4
);
  localparam int IDW = sreg_arb_pkg::idx_width(NREQ);

  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op;
  logic [W*NREQ-1:0] wdata;
  logic [NREQ-1:0]   ack;
  logic [IDW-1:0]    gnt_id;
  logic [W-1:0]      q;
  logic              busy;

  modport master (
    output req, op, wdata,
    input  ack, gnt_id, q, busy
  );

  modport slave (
    input  req, op, wdata,
    output ack, gnt_id, q, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational circular priority pick: first set bit of elig at or above ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick
  import sreg_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  win_id,
  output logic [NREQ-1:0] win_onehot
);

  int idx;

  // NOTE: every output and temporary gets a default before the search loop, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    any        = |elig;
    win_id     = '0;
    win_onehot = '0;
    idx        = 0;
    // Walk offsets from farthest to nearest so the nearest eligible bit wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (elig[idx]) begin
        win_id          = IDW'(idx);
        win_onehot      = '0;
        win_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_rr_arbiter.sv
// Round-robin sequencer for one shared W-bit register: commits one requester's
// LOAD/SET/CLR/TOG op per clock and pulses a one-hot ack to that requester.
module shared_reg_rr_arbiter
  import sreg_arb_pkg::*;
#(
  parameter int           W         = 8,
  parameter int           NREQ      = 4,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  shared_reg_rr_arbiter_if.slave  bus
);

  localparam int IDW = idx_width(NREQ);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [W-1:0]    q_q, q_d;

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] elig;
  logic            any;
  logic [IDW-1:0]  win_id;
  logic [NREQ-1:0] win_onehot;
  op_e             op_sel;
  logic [W-1:0]    op_mask;

  function automatic logic [W-1:0] apply_op(op_e o, logic [W-1:0] cur, logic [W-1:0] m);
    case (o)
      OP_LOAD: return m;
      OP_SET:  return cur | m;
      OP_CLR:  return cur & ~m;
      default: return cur ^ m;
    endcase
  endfunction

  // The requester served at the last edge still holds req in its ack cycle;
  // masking it stops a second commit of the same op.
  assign mask = (state_q == ST_ACK) ? ack_q : '0;
  assign elig = bus.req & ~mask;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .elig       (elig),
    .ptr        (ptr_q),
    .any        (any),
    .win_id     (win_id),
    .win_onehot (win_onehot)
  );

  assign op_sel  = op_e'(bus.op[2*int'(win_id) +: 2]);
  assign op_mask = bus.wdata[W*int'(win_id) +: W];

  always_comb begin
    state_d  = ST_IDLE;
    ptr_d    = ptr_q;
    ack_d    = '0;
    gnt_id_d = gnt_id_q;
    q_d      = q_q;
    if (any) begin
      state_d  = ST_ACK;
      q_d      = apply_op(op_sel, q_q, op_mask);
      ack_d    = win_onehot;
      gnt_id_d = win_id;
      ptr_d    = (int'(win_id) == NREQ - 1) ? '0 : win_id + IDW'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      ack_q    <= '0;
      gnt_id_q <= '0;
      q_q      <= RESET_VAL;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      gnt_id_q <= gnt_id_d;
      q_q      <= q_d;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.q      = q_q;
  assign bus.busy   = |elig;

endmodule
